mem_responder: RTL and testbench

Memory-side responder for the datapath's memory interface: it receives the word address from MAR, the `read`/`write` strobes and the shared 32-bit bidirectional data lines, and services each request from an internal word-addressed RAM after a programmable number of wait states. A four-phase `mem_ready` handshake tells the control unit when read data is valid on the lines or when a write has been committed. It sits outside the datapath, on the other end of `MAR_to_chip` / `MDR_Mem_lines`.

---
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: services word reads/writes from an internal RAM after a
// programmable number of wait states, with a four-phase mem_ready handshake.
module mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_BITS   = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  mem_err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_op_wr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic                   r_mem_ready;
  logic                   r_busy;
  logic                   r_mem_err;
  logic                   r_drive;
  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

  state_t                 w_state_nxt;
  logic [3:0]             w_cnt_nxt;
  logic                   w_accept;
  logic                   w_op_wr_nxt;
  logic                   w_mem_we;
  logic                   w_mem_re;
  logic                   w_err_nxt;
  logic [ADDR_BITS-1:0]   w_acc_addr;
  logic [DATA_WIDTH-1:0]  w_acc_wdata;
  logic                   w_addr_unused;

  // Upper address bits are deliberately ignored so addresses wrap.
  assign w_addr_unused = ^address[31:ADDR_BITS];

  // Next-state, access strobes and access address/data selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_op_wr_nxt = r_op_wr;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_err_nxt   = 1'b0;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (read && write) begin
          w_err_nxt = 1'b1;
        end else if (read || write) begin
          w_accept    = 1'b1;
          w_op_wr_nxt = write;
          w_acc_addr  = address[ADDR_BITS-1:0];
          w_acc_wdata = data;
          if (WAIT_STATES == 0) begin
            w_mem_we    = write;
            w_mem_re    = read;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt   = WS;
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (r_op_wr ? !write : !read) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_mem_we    = r_op_wr;
          w_mem_re    = !r_op_wr;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        if (!read && !write) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latches and registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_op_wr     <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_err   <= 1'b0;
      r_drive     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op_wr     <= w_op_wr_nxt;
      r_mem_ready <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt == ST_BUSY);
      r_mem_err   <= w_err_nxt;
      r_drive     <= (w_state_nxt == ST_DONE) && !w_op_wr_nxt;
      if (w_accept) begin
        r_addr <= w_acc_addr;
        if (write) r_wdata <= w_acc_wdata;
      end
      if (w_mem_re) r_rdata <= r_mem[w_acc_addr];
    end
  end

  // Storage has no reset; a write coinciding with clear is dropped.
  always_ff @(posedge clock) begin
    if (w_mem_we && !clear) r_mem[w_acc_addr] <= w_acc_wdata;
  end

  assign data      = r_drive ? r_rdata : {DATA_WIDTH{1'bz}};
  assign mem_ready = r_mem_ready;
  assign busy      = r_busy;
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: default build (WAIT_STATES=2) and a zero-wait build.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] addr0, addr1;
  logic        rd0, wr0, rd1, wr1;
  logic        drv0, drv1;
  logic [31:0] val0, val1;
  wire  [31:0] data0, data1;
  logic        rdy0, busy0, err0, rdy1, busy1, err1;

  assign data0 = drv0 ? val0 : 32'hzzzz_zzzz;
  assign data1 = drv1 ? val1 : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  mem_responder dut0 (
    .clock(clk), .clear(clear), .address(addr0), .read(rd0), .write(wr0),
    .data(data0), .mem_ready(rdy0), .busy(busy0), .mem_err(err0)
  );

  mem_responder #(.WAIT_STATES(0)) dut1 (
    .clock(clk), .clear(clear), .address(addr1), .read(rd1), .write(wr1),
    .data(data1), .mem_ready(rdy1), .busy(busy1), .mem_err(err1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit saw_busy1 = 1'b0;

  typedef struct {
    int          edge_no;
    bit          is_rd;
    logic [31:0] val;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic bit released(input logic [31:0] v);
    return (v === 32'hzzzz_zzzz) || (v === 32'h0000_0000);
  endfunction

  function automatic logic get_rdy(input int i);
    return (i == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic [31:0] get_bus(input int i);
    return (i == 0) ? data0 : data1;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_item(input int i, input bit have, input exp_t e);
    logic [31:0] b;
    b = get_bus(i);
    if (!have) begin
      chk(1'b0, (i == 0) ? "unexpected_ready0" : "unexpected_ready1", 32'd1, 32'd0);
    end else begin
      chk(cyc == e.edge_no, (i == 0) ? "latency0" : "latency1", 32'(cyc), 32'(e.edge_no));
      if (e.is_rd) chk(b === e.val, (i == 0) ? "rdata0" : "rdata1", b, e.val);
      else         chk(released(b), (i == 0) ? "wr_nodrive0" : "wr_nodrive1", b, 32'h0);
    end
  endtask

  // Monitor: pops the scoreboard on each rising mem_ready.
  initial begin
    bit   p0 = 1'b0;
    bit   p1 = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (busy1) saw_busy1 = 1'b1;
      if (rdy0 && !p0) begin
        e = '{edge_no: 0, is_rd: 1'b0, val: 32'h0};
        if (q0.size() > 0) begin e = q0.pop_front(); check_item(0, 1'b1, e); end
        else check_item(0, 1'b0, e);
      end
      if (rdy1 && !p1) begin
        e = '{edge_no: 0, is_rd: 1'b0, val: 32'h0};
        if (q1.size() > 0) begin e = q1.pop_front(); check_item(1, 1'b1, e); end
        else check_item(1, 1'b0, e);
      end
      p0 = rdy0;
      p1 = rdy1;
    end
  end

  task automatic set_req(input int i, input bit r, input bit w, input logic [31:0] a,
                         input bit d_en, input logic [31:0] d);
    if (i == 0) begin rd0 = r; wr0 = w; addr0 = a; drv0 = d_en; val0 = d; end
    else        begin rd1 = r; wr1 = w; addr1 = a; drv1 = d_en; val1 = d; end
  endtask

  // Full four-phase transaction; expectation pushed at issue time.
  task automatic req(input int i, input bit is_wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp, input int ws);
    exp_t e;
    bit   got;
    logic [31:0] b;
    @(negedge clk);
    set_req(i, !is_wr, is_wr, a, is_wr, d);
    e.edge_no = cyc + 1 + ws;
    e.is_rd   = !is_wr;
    e.val     = exp;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    got = 1'b0;
    for (int n = 0; n <= ws + 3; n++) begin
      @(negedge clk);
      if (n == 0) begin
        set_req(i, !is_wr, is_wr, a ^ 32'h0000_001F, 1'b0, 32'h0);
        if (i == 0 && ws > 0) chk(busy0 === 1'b1, "busy_after_accept", 32'(busy0), 32'd1);
      end
      if (get_rdy(i)) begin got = 1'b1; break; end
    end
    if (!got) chk(1'b0, "ready_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    chk(get_rdy(i) === 1'b1, "ready_held", 32'(get_rdy(i)), 32'd1);
    b = get_bus(i);
    if (!is_wr) chk(b === exp, "rdata_held", b, exp);
    set_req(i, 1'b0, 1'b0, a, 1'b0, 32'h0);
    @(negedge clk);
    chk(get_rdy(i) === 1'b0, "ready_fall", 32'(get_rdy(i)), 32'd0);
    b = get_bus(i);
    chk(released(b), "bus_release", b, 32'h0);
  endtask

  initial begin
    bit got;
    exp_t e;
    clear = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk(rdy0 === 1'b0, "rst_ready", 32'(rdy0), 32'd0);
    chk(busy0 === 1'b0, "rst_busy", 32'(busy0), 32'd0);
    chk(err0 === 1'b0, "rst_err", 32'(err0), 32'd0);
    chk(released(data0), "rst_bus", data0, 32'h0);
    clear = 1'b0;

    // Write then read, and address wrap-around.
    req(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0, 2);
    req(0, 1'b0, 32'h0000_0005, 32'h0, 32'hDEAD_BEEF, 2);
    req(0, 1'b1, 32'h0000_0203, 32'h1234_5678, 32'h0, 2);
    req(0, 1'b0, 32'h0000_0003, 32'h0, 32'h1234_5678, 2);

    // Aborted write must leave old contents.
    req(0, 1'b1, 32'h0000_0007, 32'h1111_1111, 32'h0, 2);
    @(negedge clk);
    set_req(0, 1'b0, 1'b1, 32'h7, 1'b1, 32'hAAAA_AAAA);
    @(negedge clk);
    chk(busy0 === 1'b1, "abort_busy", 32'(busy0), 32'd1);
    set_req(0, 1'b0, 1'b0, 32'h7, 1'b0, 32'h0);
    @(negedge clk);
    chk(busy0 === 1'b0, "abort_idle", 32'(busy0), 32'd0);
    chk(rdy0 === 1'b0, "abort_noready", 32'(rdy0), 32'd0);
    repeat (4) @(negedge clk);

    // Conflicting strobes: error pulse each cycle, nothing accepted.
    set_req(0, 1'b1, 1'b1, 32'h7, 1'b1, 32'h5555_5555);
    @(negedge clk);
    chk(err0 === 1'b1, "conflict_err1", 32'(err0), 32'd1);
    chk(busy0 === 1'b0, "conflict_busy1", 32'(busy0), 32'd0);
    @(negedge clk);
    chk(err0 === 1'b1, "conflict_err2", 32'(err0), 32'd1);
    chk(busy0 === 1'b0, "conflict_busy2", 32'(busy0), 32'd0);
    set_req(0, 1'b0, 1'b0, 32'h7, 1'b0, 32'h0);
    @(negedge clk);
    chk(err0 === 1'b0, "conflict_err_clr", 32'(err0), 32'd0);
    chk(rdy0 === 1'b0, "conflict_noready", 32'(rdy0), 32'd0);
    req(0, 1'b0, 32'h0000_0007, 32'h0, 32'h1111_1111, 2);

    // Asynchronous clear while read data is on the bus.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h5, 1'b0, 32'h0);
    e.edge_no = cyc + 3;
    e.is_rd   = 1'b1;
    e.val     = 32'hDEAD_BEEF;
    q0.push_back(e);
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rdy0) begin got = 1'b1; break; end
    end
    if (!got) chk(1'b0, "reset_ready_timeout", 32'd0, 32'd1);
    #2;
    clear = 1'b1;
    rd0   = 1'b0;
    #1;
    chk(rdy0 === 1'b0, "async_rst_ready", 32'(rdy0), 32'd0);
    chk(busy0 === 1'b0, "async_rst_busy", 32'(busy0), 32'd0);
    chk(err0 === 1'b0, "async_rst_err", 32'(err0), 32'd0);
    chk(released(data0), "async_rst_bus", data0, 32'h0);
    @(negedge clk);
    clear = 1'b0;

    // Zero-wait build.
    req(1, 1'b1, 32'h0000_0009, 32'hCAFE_0001, 32'h0, 0);
    req(1, 1'b0, 32'h0000_0009, 32'h0, 32'hCAFE_0001, 0);

    repeat (3) @(negedge clk);
    chk(q0.size() == 0, "q0_drained", 32'(q0.size()), 32'd0);
    chk(q1.size() == 0, "q1_drained", 32'(q1.size()), 32'd0);
    chk(!saw_busy1, "ws0_busy_never", 32'(saw_busy1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
